// File: rtl/snake_timer_pkg.sv
`default_nettype none
// =====================================================================
// Package  : snake_timer_pkg
// Brief    : Shared timer state encoding and default sizing constants.
// Revision : 1.0 - initial release
// =====================================================================
package snake_timer_pkg;

   // Defaults shared with the speed-control block
   localparam int C_DEFAULT_WIDTH       = 10;
   localparam int C_DEFAULT_RESET_LIMIT = 999;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/param_eq_cmp.sv
`default_nettype none
// =====================================================================
// Module   : param_eq_cmp
// Brief    : WIDTH-bit equality compare, per-bit xnor then AND-reduce.
// Revision : 1.0 - initial release
// =====================================================================
module param_eq_cmp #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq
);

   logic [WIDTH-1:0] w_bit_eq;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_bit_eq[i] = ~(a[i] ^ b[i]);
   end

   assign eq = &w_bit_eq;

endmodule
`default_nettype wire

// File: rtl/match_tick_timer.sv
`default_nettype none
// =====================================================================
// Module   : match_tick_timer
// Brief    : Programmable move-rate timer; ticks on count==limit, wraps,
//            and swaps in a shadowed limit only at a wrap or while idle.
// Revision : 1.0 - initial release
// =====================================================================
module match_tick_timer
   import snake_timer_pkg::*;
#(
   parameter int WIDTH       = C_DEFAULT_WIDTH,
   parameter int RESET_LIMIT = C_DEFAULT_RESET_LIMIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode_oneshot,
   input  logic             start,
   input  logic [WIDTH-1:0] limit_in,
   input  logic             limit_valid,
   output logic             limit_ready,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             eq,
   output logic             busy
);

   if (RESET_LIMIT < 0 || (WIDTH < 31 && RESET_LIMIT > (2 ** WIDTH) - 1)) begin : g_bad_reset_limit
      $error("RESET_LIMIT does not fit in WIDTH bits");
   end

   localparam logic [WIDTH-1:0] C_RESET_LIMIT = WIDTH'(RESET_LIMIT);

   state_t           r_state,  w_state_nxt;
   logic [WIDTH-1:0] r_count,  w_count_nxt;
   logic [WIDTH-1:0] r_active, w_active_nxt;
   logic [WIDTH-1:0] r_shadow, w_shadow_nxt;
   logic             r_full,   w_full_nxt;
   logic             r_tick,   w_tick_nxt;
   logic             w_eq;
   logic             w_accept;
   logic             w_match;

   param_eq_cmp #(.WIDTH(WIDTH)) u_eq_cmp (
      .a  (r_count),
      .b  (r_active),
      .eq (w_eq)
   );

   assign w_accept = limit_valid & ~r_full;
   assign w_match  = (r_state == RUN) & en & w_eq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_active <= C_RESET_LIMIT;
         r_shadow <= '0;
         r_full   <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_active <= w_active_nxt;
         r_shadow <= w_shadow_nxt;
         r_full   <= w_full_nxt;
         r_tick   <= w_tick_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_active_nxt = r_active;
      w_shadow_nxt = r_shadow;
      w_full_nxt   = r_full;
      w_tick_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            w_count_nxt = '0;
            if (r_full) begin
               w_active_nxt = r_shadow;
               w_full_nxt   = 1'b0;
            end
            if (!mode_oneshot || start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_match) begin
               w_count_nxt = '0;
               w_tick_nxt  = 1'b1;
               if (r_full) begin
                  w_active_nxt = r_shadow;
                  w_full_nxt   = 1'b0;
               end
               if (mode_oneshot) begin
                  w_state_nxt = IDLE;
               end
            end else if (en) begin
               w_count_nxt = r_count + WIDTH'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Accepting only when empty means a value taken at a match waits for the next one
      if (w_accept) begin
         w_shadow_nxt = limit_in;
         w_full_nxt   = 1'b1;
      end
   end

   assign limit_ready = ~r_full;
   assign count       = r_count;
   assign tick        = r_tick;
   assign eq          = w_eq;
   assign busy        = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_match_tick_timer.sv
`default_nettype none
// =====================================================================
// Module   : tb_match_tick_timer
// Brief    : Scoreboard bench with a queue-based reference model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_match_tick_timer;

   localparam int W  = 4;
   localparam int RL = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         mode_oneshot;
   logic         start;
   logic [W-1:0] limit_in;
   logic         limit_valid;
   logic         limit_ready;
   logic [W-1:0] count;
   logic         tick;
   logic         eq;
   logic         busy;

   always #5 clk = ~clk;

   match_tick_timer #(.WIDTH(W), .RESET_LIMIT(RL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .mode_oneshot (mode_oneshot),
      .start        (start),
      .limit_in     (limit_in),
      .limit_valid  (limit_valid),
      .limit_ready  (limit_ready),
      .count        (count),
      .tick         (tick),
      .eq           (eq),
      .busy         (busy)
   );

   typedef struct {
      int cnt;
      bit tck;
      bit bsy;
      bit rdy;
      bit equ;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: running flag, integer count, limit, shadow as a 0/1-deep queue
   bit   m_run;
   int   m_cnt;
   int   m_limit;
   int   m_shadow[$];
   bit   m_tick;
   bit   p_valid;
   int   p_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run   = 1'b0;
      m_cnt   = 0;
      m_limit = RL;
      m_shadow.delete();
      m_tick  = 1'b0;
      p_valid = 1'b0;
      p_data  = 0;
   endtask

   // Drive inputs for the coming edge and predict what follows it
   task automatic step(input bit e, input bit mo, input bit st);
      bit   acc;
      exp_t x;
      en           = e;
      mode_oneshot = mo;
      start        = st;
      limit_valid  = p_valid;
      limit_in     = W'(p_data);
      acc    = p_valid && (m_shadow.size() == 0);
      m_tick = 1'b0;
      if (!m_run) begin
         if (m_shadow.size() > 0) m_limit = m_shadow.pop_front();
         if (!mo || st) m_run = 1'b1;
      end else if (e) begin
         if (m_cnt == m_limit) begin
            m_cnt  = 0;
            m_tick = 1'b1;
            if (m_shadow.size() > 0) m_limit = m_shadow.pop_front();
            if (mo) m_run = 1'b0;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
      if (acc) begin
         m_shadow.push_back(p_data);
         p_valid = 1'b0;
      end
      x.cnt = m_cnt;
      x.tck = m_tick;
      x.bsy = m_run;
      x.rdy = (m_shadow.size() == 0);
      x.equ = (m_cnt == m_limit);
      sb_q.push_back(x);
   endtask

   task automatic cycle(input bit e, input bit mo, input bit st);
      @(negedge clk);
      #1;
      step(e, mo, st);
   endtask

   task automatic run_until_idle(input bit e, input int bound);
      int n = 0;
      while (m_run && n < bound) begin
         cycle(e, 1'b1, 1'b0);
         n++;
      end
      if (m_run) chk("oneshot_timeout", 32'd1, 32'd0);
   endtask

   // Monitor: one expectation per clock edge, compared mid-cycle
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("count", 32'(count), 32'(x.cnt));
            chk("tick", 32'(tick), 32'(x.tck));
            chk("busy", 32'(busy), 32'(x.bsy));
            chk("limit_ready", 32'(limit_ready), 32'(x.rdy));
            chk("eq", 32'(eq), 32'(x.equ));
         end
      end
   end

   initial begin
      int n;
      rst_n        = 1'b0;
      en           = 1'b0;
      mode_oneshot = 1'b0;
      start        = 1'b0;
      limit_valid  = 1'b0;
      limit_in     = '0;
      model_reset();
      #12;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(limit_ready), 32'd1);
      chk("rst_eq", 32'(eq), 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);

      // Free-running periodic count, then en toggling
      repeat (12) cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) cycle(i % 2 == 0, 1'b0, 1'b0);

      // Load 5 while count==1, then hold a second value while not ready
      n = 0;
      while (!(m_run && m_cnt == 1) && n < 20) begin
         cycle(1'b1, 1'b0, 1'b0);
         n++;
      end
      if (n >= 20) chk("load_wait_timeout", 32'd1, 32'd0);
      p_valid = 1'b1;
      p_data  = 5;
      cycle(1'b1, 1'b0, 1'b0);
      p_valid = 1'b1;
      p_data  = 7;
      repeat (24) cycle(1'b1, 1'b0, 1'b0);
      p_valid = 1'b0;

      // One-shot: finish current period, idle, start, ignored start, re-arm
      run_until_idle(1'b1, 40);
      repeat (3) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      repeat (3) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      run_until_idle(1'b1, 40);
      cycle(1'b0, 1'b1, 1'b1);
      run_until_idle(1'b1, 40);

      // Async reset mid-count with a full shadow
      repeat (5) cycle(1'b1, 1'b0, 1'b0);
      p_valid = 1'b1;
      p_data  = 9;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_tick", 32'(tick), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_ready", 32'(limit_ready), 32'd1);
      chk("async_eq", 32'(eq), 32'd0);
      model_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);

      // Limit 0 accepted on the same edge as a match
      n = 0;
      while (!(m_run && m_cnt == m_limit && m_shadow.size() == 0) && n < 20) begin
         cycle(1'b1, 1'b0, 1'b0);
         n++;
      end
      if (n >= 20) chk("match_wait_timeout", 32'd1, 32'd0);
      p_valid = 1'b1;
      p_data  = 0;
      cycle(1'b1, 1'b0, 1'b0);
      repeat (10) cycle(1'b1, 1'b0, 1'b0);
      p_valid = 1'b1;
      p_data  = 2;
      repeat (6) cycle(1'b1, 1'b0, 1'b0);

      // Randomised traffic
      begin
         bit mo = 1'b0;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mo = ~mo;
            if (!p_valid && $urandom_range(0, 5) == 0) begin
               p_valid = 1'b1;
               p_data  = int'($urandom_range(0, 6));
            end
            cycle($urandom_range(0, 3) != 0, mo, $urandom_range(0, 4) == 0);
         end
      end

      repeat (2) @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
